// File: rtl/segment_display_arbiter.sv
// Round-robin arbiter sharing a 3-digit segment display between NUM_REQ requesters.
// Optional preemption by requester 0 is enabled with SEGMENT_DISPLAY_ARBITER_PREEMPT_EN.
module segment_display_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [15*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ack_o,
  output logic [14:0]           disp_data_o,
  output logic                  disp_update_o,
  output logic [IDX_W-1:0]      active_idx_o,
  output logic                  busy_o
);

  localparam int unsigned      NumIdx    = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] DwellInit = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LastInit  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StStrobe, StShow} state_e;

  state_e             state_q, state_d;
  logic [14:0]        disp_data_q, disp_data_d;
  logic               disp_update_q, disp_update_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [IDX_W-1:0]   active_idx_q, active_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Pad requests and slices to the full index space so undriven indices read as idle.
  logic [NumIdx-1:0] valid_pad;
  logic [14:0]       slice [NumIdx];

  for (genvar i = 0; i < NumIdx; i++) begin : g_pad
    if (i < NUM_REQ) begin : g_drv
      assign valid_pad[i] = req_valid_i[i];
      assign slice[i]     = req_data_i[15*i +: 15];
    end else begin : g_tie
      assign valid_pad[i] = 1'b0;
      assign slice[i]     = '0;
    end
  end

  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] gnt_idx;
  logic             rr_found;
  logic [31:0]      cand_sum;
  logic [IDX_W-1:0] cand_idx;

  // First set request strictly after the pointer, wrapping; the pointer itself is checked last.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand_sum = '0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_sum = 32'(last_q) + k;
      if (cand_sum >= NUM_REQ) begin
        cand_sum = cand_sum - NUM_REQ;
      end
      cand_idx = IDX_W'(cand_sum);
      if (!rr_found && valid_pad[cand_idx]) begin
        rr_idx   = cand_idx;
        rr_found = 1'b1;
      end
    end
  end

`ifdef SEGMENT_DISPLAY_ARBITER_PREEMPT_EN
  always_comb begin
    if (valid_pad[0]) begin
      gnt_idx = '0;
    end else begin
      gnt_idx = rr_idx;
    end
  end
`else
  assign gnt_idx = rr_idx;
`endif

  logic [NumIdx-1:0] ack_pad;

  always_comb begin
    ack_pad          = '0;
    ack_pad[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    disp_data_d   = disp_data_q;
    disp_update_d = 1'b0;
    req_ack_d     = '0;
    active_idx_d  = active_idx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          disp_data_d  = slice[gnt_idx];
          req_ack_d    = ack_pad[NUM_REQ-1:0];
          active_idx_d = gnt_idx;
          last_d       = gnt_idx;
          state_d      = StStrobe;
        end
      end
      StStrobe: begin
        disp_update_d = 1'b1;
        cnt_d         = DwellInit;
        state_d       = StShow;
      end
      StShow: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`ifdef SEGMENT_DISPLAY_ARBITER_PREEMPT_EN
        // Error source cuts short any other requester's dwell.
        if ((active_idx_q != '0) && req_valid_i[0]) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      disp_data_q   <= '0;
      disp_update_q <= 1'b0;
      req_ack_q     <= '0;
      active_idx_q  <= '0;
      last_q        <= LastInit;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      disp_data_q   <= disp_data_d;
      disp_update_q <= disp_update_d;
      req_ack_q     <= req_ack_d;
      active_idx_q  <= active_idx_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign disp_data_o   = disp_data_q;
  assign disp_update_o = disp_update_q;
  assign req_ack_o     = req_ack_q;
  assign active_idx_o  = active_idx_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/segment_display_arbiter.md
Name: segment_display_arbiter

Overview:
- Shares the 3-digit multiplexed segment display between up to NUM_REQ miner subsystems (e.g. hashrate, nonce progress, status, error code).
- Grants requesters round-robin and holds each granted value on screen for a programmable dwell time.
- Drives the 15-bit display word and the one-cycle update strobe of the display driver, which latches the word on the rising edge of update.
- Data is always stable one cycle before the strobe.

Parameters:
- NUM_REQ, 4: number of requesters, 2..4.
- IDX_W, 2: width of the grant index; must satisfy 2^IDX_W >= NUM_REQ.
- DWELL_CYCLES, 50000000: clk cycles spent in SHOW per grant; minimum 1.
- CNT_W, 26: dwell counter width; must hold DWELL_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request bit per requester; level, sampled only in IDLE
- req_data  in  15*NUM_REQ  requester i occupies bits [15*i+14:15*i]; bits [11:0] are three hex digits, [14:12] are the decimal-point enables
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse when the requester's word is latched
- disp_data  out  15  word to the display driver
- disp_update  out  1  one-cycle strobe to the display driver
- active_idx  out  IDX_W  index of the requester currently shown
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, asynchronous) sets all state and outputs immediately:
  - state = IDLE, disp_data = 0, disp_update = 0, req_ack = 0, active_idx = 0, busy = 0.
  - Dwell counter = 0, round-robin pointer last = NUM_REQ-1.
  - Any pulse in flight is aborted; no update is issued after reset releases until a new grant.
- All outputs are registered.
- State IDLE:
  - If any req_valid bit is set, the next edge grants g, the first set bit searching (last+1) mod NUM_REQ upward with wrap.
  - On that edge: disp_data <= slice g, req_ack <= onehot(g), active_idx <= g, last <= g, state <= STROBE.
  - If no request is pending, remain in IDLE and disp_data holds its last value indefinitely.
- State STROBE, one cycle:
  - Next edge: req_ack <= 0, disp_update <= 1, counter <= DWELL_CYCLES-1, state <= SHOW.
- State SHOW:
  - disp_update returns to 0 on the first edge.
  - The counter decrements each edge. On the edge where counter == 0, state <= IDLE.
- Latency and period:
  - IDLE sample edge to req_ack high: 1 edge. To disp_update high: 2 edges.
  - With continuous requests, disp_update pulses are exactly DWELL_CYCLES+2 cycles apart.
- A single persistent requester is re-granted every period; the same data is still re-strobed.
- req_valid or req_data changes outside IDLE have no effect; the word was latched at grant.
- Simultaneous requests are resolved strictly by pointer order, so no requester is granted twice while another valid requester waits.
- Undriven indices (NUM_REQ < 2^IDX_W) are never granted.

Optional Feature:
- Macro: SEGMENT_DISPLAY_ARBITER_PREEMPT_EN.
- When defined:
  - Requester 0 is the priority (error) source. In IDLE it wins whenever req_valid[0] is set, regardless of the pointer.
  - In SHOW with active_idx != 0, req_valid[0] high forces state <= IDLE on the next edge; the remaining dwell is discarded.
  - The pointer still updates on every grant.
- When undefined: pure round-robin, with no preemption logic present.

Test Plan (bench uses DWELL_CYCLES=8, NUM_REQ=4):
1. Reset with rst low, then release with all req_valid=0 -> disp_data=0, disp_update never pulses, busy=0.
2. req_valid=4'b0001 held, req_data slice0=15'h7123 -> req_ack=0001 one edge after sampling, disp_data=7123 at that edge, disp_update high one cycle later, repeating every 10 cycles.
3. req_valid=4'b1111 held with distinct slices -> grants in order 0,1,2,3,0; active_idx follows; each strobe 10 cycles apart.
4. rst asserted during STROBE -> disp_update stays 0, outputs zero immediately (asynchronous), no stray pulse after release.
5. Only req 2 valid, then req 2 drops during SHOW while req 1 rises -> no effect until IDLE, then grant 1 (pointer wraps 3->0->1).
6. With PREEMPT_EN: showing requester 3, set req_valid[0] mid-SHOW -> IDLE next edge, grant 0 on the following edge, disp_update 3 cycles after the assertion of req_valid[0]. Without PREEMPT_EN the full dwell completes first.
